// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two requesters (VGA fetch, CPU) and the SRAM pads.
// The arbiter uses the slave view; requesters and the pad/SRAM side use the master view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              iVGA_REQ;
  logic [ADDR_W-1:0] iVGA_ADDR;
  logic              oVGA_ACK;
  logic              oVGA_VALID;
  logic [DATA_W-1:0] oVGA_DATA;

  logic              iCPU_REQ;
  logic              iCPU_WE;
  logic [ADDR_W-1:0] iCPU_ADDR;
  logic [DATA_W-1:0] iCPU_WDATA;
  logic [1:0]        iCPU_BE;
  logic              oCPU_ACK;
  logic              oCPU_RVALID;
  logic [DATA_W-1:0] oCPU_RDATA;

  logic [ADDR_W-1:0] oSRAM_ADDR;
  logic [DATA_W-1:0] iSRAM_DQ;
  logic [DATA_W-1:0] oSRAM_DQ;
  logic              oSRAM_DQ_OE;
  logic              oWE_N;
  logic              oOE_N;
  logic              oCE_N;
  logic              oLB_N;
  logic              oUB_N;
  logic [2:0]        oSTATE;

  modport slave (
    input  iVGA_REQ, iVGA_ADDR, iCPU_REQ, iCPU_WE, iCPU_ADDR, iCPU_WDATA, iCPU_BE, iSRAM_DQ,
    output oVGA_ACK, oVGA_VALID, oVGA_DATA, oCPU_ACK, oCPU_RVALID, oCPU_RDATA,
           oSRAM_ADDR, oSRAM_DQ, oSRAM_DQ_OE, oWE_N, oOE_N, oCE_N, oLB_N, oUB_N, oSTATE
  );

  modport master (
    output iVGA_REQ, iVGA_ADDR, iCPU_REQ, iCPU_WE, iCPU_ADDR, iCPU_WDATA, iCPU_BE, iSRAM_DQ,
    input  oVGA_ACK, oVGA_VALID, oVGA_DATA, oCPU_ACK, oCPU_RVALID, oCPU_RDATA,
           oSRAM_ADDR, oSRAM_DQ, oSRAM_DQ_OE, oWE_N, oOE_N, oCE_N, oLB_N, oUB_N, oSTATE
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between the VGA fetch port (priority) and the CPU port.
// Two-cycle reads, three-cycle writes, all SRAM pins registered; CPU is guaranteed a slot every VGA_BURST grants.
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int VGA_BURST = 4
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  sram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VRD_A = 3'd1,
    VRD_D = 3'd2,
    CRD_A = 3'd3,
    CRD_D = 3'd4,
    WR_S  = 3'd5,
    WR_P  = 3'd6,
    WR_H  = 3'd7
  } stateT;

  stateT      state;
  logic [3:0] runCnt;
  logic       arbNow;
  logic       cpuWins;
  logic       grantVga;
  logic       grantCpu;

  // Arbitration happens only where the next transaction may start: IDLE and each final state.
  always_comb begin
    arbNow   = (state == IDLE) || (state == VRD_D) || (state == CRD_D) || (state == WR_H);
    cpuWins  = bus.iCPU_REQ && (!bus.iVGA_REQ || (runCnt == 4'(VGA_BURST)));
    grantCpu = arbNow && cpuWins;
    grantVga = arbNow && bus.iVGA_REQ && !cpuWins;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      runCnt <= 4'd0;
    end else if (!bus.iCPU_REQ || grantCpu) begin
      runCnt <= 4'd0;
    end else if (grantVga) begin
      runCnt <= runCnt + 4'd1;
    end
  end

  // Strobes, address and write data are set on the grant edge and simply held through the
  // transaction; only WE_N toggles mid-write.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state           <= IDLE;
      bus.oVGA_ACK    <= 1'b0;
      bus.oVGA_VALID  <= 1'b0;
      bus.oVGA_DATA   <= {DATA_W{1'b0}};
      bus.oCPU_ACK    <= 1'b0;
      bus.oCPU_RVALID <= 1'b0;
      bus.oCPU_RDATA  <= {DATA_W{1'b0}};
      bus.oSRAM_ADDR  <= {ADDR_W{1'b0}};
      bus.oSRAM_DQ    <= {DATA_W{1'b0}};
      bus.oSRAM_DQ_OE <= 1'b0;
      bus.oWE_N       <= 1'b1;
      bus.oOE_N       <= 1'b1;
      bus.oCE_N       <= 1'b1;
      bus.oLB_N       <= 1'b1;
      bus.oUB_N       <= 1'b1;
    end else begin
      bus.oVGA_ACK    <= 1'b0;
      bus.oVGA_VALID  <= 1'b0;
      bus.oCPU_ACK    <= 1'b0;
      bus.oCPU_RVALID <= 1'b0;
      case (state)
        VRD_A: state <= VRD_D;
        CRD_A: state <= CRD_D;
        WR_S: begin
          state     <= WR_P;
          bus.oWE_N <= 1'b0;
        end
        WR_P: begin
          state     <= WR_H;
          bus.oWE_N <= 1'b1;
        end
        default: begin
          if (state == VRD_D) begin
            bus.oVGA_DATA  <= bus.iSRAM_DQ;
            bus.oVGA_VALID <= 1'b1;
          end
          if (state == CRD_D) begin
            bus.oCPU_RDATA  <= bus.iSRAM_DQ;
            bus.oCPU_RVALID <= 1'b1;
          end
          if (grantVga) begin
            state           <= VRD_A;
            bus.oVGA_ACK    <= 1'b1;
            bus.oSRAM_ADDR  <= bus.iVGA_ADDR;
            bus.oSRAM_DQ_OE <= 1'b0;
            bus.oCE_N       <= 1'b0;
            bus.oOE_N       <= 1'b0;
            bus.oWE_N       <= 1'b1;
            bus.oLB_N       <= 1'b0;
            bus.oUB_N       <= 1'b0;
          end else if (grantCpu) begin
            state           <= bus.iCPU_WE ? WR_S : CRD_A;
            bus.oCPU_ACK    <= 1'b1;
            bus.oSRAM_ADDR  <= bus.iCPU_ADDR;
            bus.oSRAM_DQ    <= bus.iCPU_WDATA;
            bus.oSRAM_DQ_OE <= bus.iCPU_WE;
            bus.oCE_N       <= 1'b0;
            bus.oOE_N       <= bus.iCPU_WE;
            bus.oWE_N       <= 1'b1;
            bus.oLB_N       <= ~bus.iCPU_BE[0];
            bus.oUB_N       <= ~bus.iCPU_BE[1];
          end else begin
            state           <= IDLE;
            bus.oSRAM_DQ_OE <= 1'b0;
            bus.oCE_N       <= 1'b1;
            bus.oOE_N       <= 1'b1;
            bus.oWE_N       <= 1'b1;
            bus.oLB_N       <= 1'b1;
            bus.oUB_N       <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.oSTATE = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed timing scenarios plus randomized two-port traffic
// scored against a reference memory, with an SRAM behavioural model on the pads.
module tb_sram_arbiter;

  logic iCLK;
  logic iRST_N;
  logic clkRun;

  int nCmp;
  int nErr;
  int cyc;

  logic [15:0] mem    [0:1023];
  logic [15:0] refMem [0:1023];
  logic [15:0] vgaQ[$];
  logic [15:0] cpuQ[$];
  byte         grantLog[$];
  int          vgaAckCyc[$];
  int          vgaValCyc[$];

  logic        prevWeN;
  logic [19:0] prevAddr;
  logic [15:0] prevDq;
  bit          holdChk;

  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .VGA_BURST(4)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus)
  );

  initial begin
    iCLK = 1'b0;
    wait (clkRun);
    forever #5 iCLK = ~iCLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] initVal(input int i);
    if (i == 'h25F) return 16'hF81F;
    if (i == 'h345) return 16'h1234;
    return 16'((i * 40503) ^ 23130);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic stepCyc();
    @(posedge iCLK);
    #1;
  endtask

  // Asynchronous SRAM: read is combinational under CE/OE, write commits at the end of the WE pulse.
  assign bus.iSRAM_DQ = (!bus.oCE_N && !bus.oOE_N) ? mem[bus.oSRAM_ADDR[9:0]] : 16'hDEAD;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = initVal(i);
    forever begin
      @(posedge iCLK);
      if (!bus.oCE_N && !bus.oWE_N) begin
        if (!bus.oLB_N) mem[bus.oSRAM_ADDR[9:0]][7:0]  = bus.oSRAM_DQ[7:0];
        if (!bus.oUB_N) mem[bus.oSRAM_ADDR[9:0]][15:8] = bus.oSRAM_DQ[15:8];
      end
    end
  end

  // Scoreboard monitors: pop expected read data whenever a VALID pulse appears.
  initial begin
    forever begin
      stepCyc();
      if (bus.oVGA_VALID) begin
        if (vgaQ.size() == 0) chk("vga_unexpected_valid", 32'd1, 32'd0);
        else chk("vga_rdata", 32'(bus.oVGA_DATA), 32'(vgaQ.pop_front()));
      end
      if (bus.oCPU_RVALID) begin
        if (cpuQ.size() == 0) chk("cpu_unexpected_rvalid", 32'd1, 32'd0);
        else chk("cpu_rdata", 32'(bus.oCPU_RDATA), 32'(cpuQ.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge iCLK);
      #1;
      cyc++;
      if (bus.oVGA_ACK) begin
        grantLog.push_back("V");
        vgaAckCyc.push_back(cyc);
      end
      if (bus.oCPU_ACK) grantLog.push_back("C");
      if (bus.oVGA_VALID) vgaValCyc.push_back(cyc);
    end
  end

  // Write-pulse checker: one-cycle WE, address/data stable one cycle either side.
  initial begin
    prevWeN = 1'b1;
    holdChk = 1'b0;
    prevAddr = '0;
    prevDq = '0;
    forever begin
      stepCyc();
      if (holdChk && iRST_N) begin
        chk("wr_hold_addr", 32'(bus.oSRAM_ADDR), 32'(prevAddr));
        chk("wr_hold_dq", 32'(bus.oSRAM_DQ), 32'(prevDq));
      end
      holdChk = 1'b0;
      if (!bus.oWE_N) begin
        chk("we_pulse_width", 32'(prevWeN), 32'd1);
        chk("we_strobes", 32'({bus.oCE_N, bus.oOE_N, bus.oSRAM_DQ_OE}), 32'b011);
        chk("wr_setup_addr", 32'(bus.oSRAM_ADDR), 32'(prevAddr));
        chk("wr_setup_dq", 32'(bus.oSRAM_DQ), 32'(prevDq));
        holdChk = 1'b1;
      end
      prevWeN  = bus.oWE_N;
      prevAddr = bus.oSRAM_ADDR;
      prevDq   = bus.oSRAM_DQ;
    end
  end

  task automatic vgaRead(input logic [19:0] a);
    bit got = 0;
    bus.iVGA_REQ  = 1'b1;
    bus.iVGA_ADDR = a;
    vgaQ.push_back(refMem[a[9:0]]);
    for (int n = 0; n < 60; n++) begin
      stepCyc();
      if (bus.oVGA_ACK) begin
        got = 1;
        break;
      end
    end
    chk("vga_ack_seen", 32'(got), 32'd1);
    bus.iVGA_REQ = 1'b0;
  endtask

  task automatic cpuOp(input logic we, input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
    bit got = 0;
    bus.iCPU_REQ   = 1'b1;
    bus.iCPU_WE    = we;
    bus.iCPU_ADDR  = a;
    bus.iCPU_WDATA = d;
    bus.iCPU_BE    = be;
    if (we) begin
      if (be[0]) refMem[a[9:0]][7:0]  = d[7:0];
      if (be[1]) refMem[a[9:0]][15:8] = d[15:8];
    end else begin
      cpuQ.push_back(refMem[a[9:0]]);
    end
    for (int n = 0; n < 60; n++) begin
      stepCyc();
      if (bus.oCPU_ACK) begin
        got = 1;
        break;
      end
    end
    chk("cpu_ack_seen", 32'(got), 32'd1);
    bus.iCPU_REQ = 1'b0;
  endtask

  function automatic logic [19:0] vgaAddr();
    logic [19:0] a;
    a = 20'($urandom);
    a[9] = 1'b0;
    return a;
  endfunction

  function automatic logic [19:0] cpuAddr();
    logic [19:0] a;
    a = 20'($urandom);
    a[9] = 1'b1;
    return a;
  endfunction

  initial begin
    nCmp = 0;
    nErr = 0;
    cyc = 0;
    clkRun = 1'b0;
    iRST_N = 1'b1;
    bus.iVGA_REQ = 1'b0;
    bus.iVGA_ADDR = '0;
    bus.iCPU_REQ = 1'b0;
    bus.iCPU_WE = 1'b0;
    bus.iCPU_ADDR = '0;
    bus.iCPU_WDATA = '0;
    bus.iCPU_BE = 2'b00;
    for (int i = 0; i < 1024; i++) refMem[i] = initVal(i);

    // Asynchronous reset with the clock stopped.
    #1 iRST_N = 1'b0;
    #2;
    chk("rst_state", 32'(bus.oSTATE), 32'd0);
    chk("rst_strobes", 32'({bus.oCE_N, bus.oOE_N, bus.oWE_N, bus.oLB_N, bus.oUB_N}), 32'h1F);
    chk("rst_dq_oe", 32'(bus.oSRAM_DQ_OE), 32'd0);
    chk("rst_addr", 32'(bus.oSRAM_ADDR), 32'd0);
    chk("rst_dq", 32'(bus.oSRAM_DQ), 32'd0);
    chk("rst_ack_valid", 32'({bus.oVGA_ACK, bus.oVGA_VALID, bus.oCPU_ACK, bus.oCPU_RVALID}), 32'd0);
    chk("rst_data", 32'({bus.oVGA_DATA, bus.oCPU_RDATA}), 32'd0);
    clkRun = 1'b1;
    repeat (3) @(posedge iCLK);
    #2 iRST_N = 1'b1;
    stepCyc();
    stepCyc();
    chk("post_rst_state", 32'(bus.oSTATE), 32'd0);
    chk("post_rst_strobes", 32'({bus.oCE_N, bus.oOE_N, bus.oWE_N, bus.oLB_N, bus.oUB_N}), 32'h1F);

    // Single VGA read, cycle by cycle.
    bus.iVGA_REQ  = 1'b1;
    bus.iVGA_ADDR = 20'h00A5F;
    vgaQ.push_back(refMem[10'h25F]);
    stepCyc();
    chk("vrd_c1_ack", 32'(bus.oVGA_ACK), 32'd1);
    chk("vrd_c1_state", 32'(bus.oSTATE), 32'd1);
    chk("vrd_c1_addr", 32'(bus.oSRAM_ADDR), 32'h00A5F);
    chk("vrd_c1_strobes", 32'({bus.oCE_N, bus.oOE_N, bus.oWE_N, bus.oLB_N, bus.oUB_N}), 32'b00100);
    bus.iVGA_REQ = 1'b0;
    stepCyc();
    chk("vrd_c2_state", 32'(bus.oSTATE), 32'd2);
    chk("vrd_c2_ack", 32'(bus.oVGA_ACK), 32'd0);
    chk("vrd_c2_addr", 32'(bus.oSRAM_ADDR), 32'h00A5F);
    chk("vrd_c2_oe", 32'(bus.oOE_N), 32'd0);
    stepCyc();
    chk("vrd_c3_valid", 32'(bus.oVGA_VALID), 32'd1);
    chk("vrd_c3_data", 32'(bus.oVGA_DATA), 32'hF81F);
    chk("vrd_c3_state", 32'(bus.oSTATE), 32'd0);
    stepCyc();
    chk("vrd_c4_valid", 32'(bus.oVGA_VALID), 32'd0);
    chk("vrd_data_hold", 32'(bus.oVGA_DATA), 32'hF81F);

    // CPU byte write, cycle by cycle.
    bus.iCPU_REQ   = 1'b1;
    bus.iCPU_WE    = 1'b1;
    bus.iCPU_ADDR  = 20'h12345;
    bus.iCPU_WDATA = 16'hABCD;
    bus.iCPU_BE    = 2'b01;
    refMem[10'h345][7:0] = 8'hCD;
    stepCyc();
    chk("wr_s_ack", 32'(bus.oCPU_ACK), 32'd1);
    chk("wr_s_state", 32'(bus.oSTATE), 32'd5);
    chk("wr_s_strobes", 32'({bus.oCE_N, bus.oOE_N, bus.oWE_N, bus.oLB_N, bus.oUB_N}), 32'b01101);
    chk("wr_s_dq", 32'({bus.oSRAM_DQ_OE, bus.oSRAM_DQ}), 32'h1ABCD);
    chk("wr_s_addr", 32'(bus.oSRAM_ADDR), 32'h12345);
    bus.iCPU_REQ = 1'b0;
    stepCyc();
    chk("wr_p_state", 32'(bus.oSTATE), 32'd6);
    chk("wr_p_strobes", 32'({bus.oCE_N, bus.oOE_N, bus.oWE_N, bus.oLB_N, bus.oUB_N}), 32'b01001);
    chk("wr_p_dq_oe", 32'(bus.oSRAM_DQ_OE), 32'd1);
    stepCyc();
    chk("wr_h_state", 32'(bus.oSTATE), 32'd7);
    chk("wr_h_we", 32'(bus.oWE_N), 32'd1);
    chk("wr_h_dq_oe", 32'(bus.oSRAM_DQ_OE), 32'd1);
    stepCyc();
    chk("wr_end_dq_oe", 32'(bus.oSRAM_DQ_OE), 32'd0);
    chk("wr_end_strobes", 32'({bus.oCE_N, bus.oOE_N, bus.oWE_N, bus.oLB_N, bus.oUB_N}), 32'h1F);
    chk("wr_mem_bytes", 32'(mem[10'h345]), 32'h12CD);
    cpuOp(1'b0, 20'h12345, 16'h0000, 2'b11);
    repeat (3) stepCyc();

    // Back-to-back VGA reads: one grant every two cycles.
    grantLog.delete();
    vgaAckCyc.delete();
    vgaValCyc.delete();
    for (int k = 0; k < 6; k++) vgaRead(20'h00100 + 20'(k));
    repeat (4) stepCyc();
    chk("b2b_ack_count", 32'(vgaAckCyc.size()), 32'd6);
    chk("b2b_valid_count", 32'(vgaValCyc.size()), 32'd6);
    for (int k = 1; k < vgaAckCyc.size(); k++)
      chk("b2b_ack_spacing", 32'(vgaAckCyc[k] - vgaAckCyc[k-1]), 32'd2);
    for (int k = 1; k < vgaValCyc.size(); k++)
      chk("b2b_valid_spacing", 32'(vgaValCyc[k] - vgaValCyc[k-1]), 32'd2);

    // Starvation bound: both ports continuously requesting.
    grantLog.delete();
    fork
      begin
        for (int k = 0; k < 12; k++) vgaRead(vgaAddr());
      end
      begin
        for (int k = 0; k < 3; k++) cpuOp(1'b0, cpuAddr(), 16'h0000, 2'($urandom));
      end
    join
    repeat (4) stepCyc();
    chk("starve_grant_count", 32'(grantLog.size()), 32'd15);
    for (int k = 0; k < grantLog.size() && k < 15; k++)
      chk("starve_grant_order", 32'(grantLog[k]), (k % 5 == 4) ? 32'("C") : 32'("V"));

    // Randomized mixed traffic.
    fork
      begin
        for (int k = 0; k < 120; k++) begin
          repeat ($urandom_range(0, 3)) stepCyc();
          vgaRead(vgaAddr());
        end
      end
      begin
        for (int k = 0; k < 80; k++) begin
          repeat ($urandom_range(0, 4)) stepCyc();
          cpuOp(1'($urandom), cpuAddr(), 16'($urandom), 2'($urandom));
        end
      end
    join
    for (int n = 0; n < 20 && (vgaQ.size() != 0 || cpuQ.size() != 0); n++) stepCyc();
    chk("vga_queue_drained", 32'(vgaQ.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cpuQ.size()), 32'd0);
    repeat (3) stepCyc();

    // Reset asserted during WR_P aborts the write immediately.
    begin
      bit got = 0;
      bus.iCPU_REQ   = 1'b1;
      bus.iCPU_WE    = 1'b1;
      bus.iCPU_ADDR  = 20'h00321;
      bus.iCPU_WDATA = 16'h5AA5;
      bus.iCPU_BE    = 2'b11;
      for (int n = 0; n < 20; n++) begin
        stepCyc();
        if (bus.oCPU_ACK) begin
          got = 1;
          break;
        end
      end
      chk("abort_ack_seen", 32'(got), 32'd1);
      bus.iCPU_REQ = 1'b0;
      stepCyc();
      chk("abort_in_wr_p", 32'({bus.oSTATE, bus.oWE_N}), 32'({3'd6, 1'b0}));
      #2 iRST_N = 1'b0;
      #1;
      chk("abort_we_high", 32'(bus.oWE_N), 32'd1);
      chk("abort_dq_released", 32'(bus.oSRAM_DQ_OE), 32'd0);
      chk("abort_state", 32'(bus.oSTATE), 32'd0);
      repeat (2) @(posedge iCLK);
      #2 iRST_N = 1'b1;
      for (int n = 0; n < 3; n++) begin
        stepCyc();
        chk("abort_no_ack", 32'(bus.oCPU_ACK), 32'd0);
        chk("abort_idle", 32'(bus.oSTATE), 32'd0);
      end
      chk("abort_mem_untouched", 32'(mem[10'h321]), 32'(refMem[10'h321]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
